// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// IF stage of the pipeline. It owns the program counter and the IF/ID
// pipeline register, and it fetches over a req/ready instruction-memory
// port whose responses may take several cycles.
//
// Stall and redirect control both come from ID:
//   * pc_load / if_id_load (hazard unit) freeze the PC and the IF/ID register.
//   * mux3_selector / branch_address redirect the fetch stream when a branch
//     is taken.
// A one-entry hold buffer captures a word that returns while ID is stalled.
// That word is handed to ID on release, so it is never lost and never
// fetched a second time.
//
// Parameters
//   RESET_PC        PC value after reset (word aligned)
//   NOP_INSTR       bubble word written into IF/ID (addi x0,x0,0)
//
// Ports
//   clock           in   1   single clock, rising edge
//   reset           in   1   asynchronous reset, active low
//   pc_load         in   1   0 = PC must not advance
//   if_id_load      in   1   0 = IF/ID holds (ID stalled)
//   mux3_selector   in   1   branch taken, resolved in ID
//   branch_address  in  32   redirect target; bits [1:0] are ignored
//   imem_req        out  1   fetch request
//   imem_addr       out 32   fetch address; stable while a request waits
//   imem_ready      in   1   response valid this cycle
//   imem_rdata      in  32   fetched instruction
//   instruction_out out 32   IF/ID instruction, to ID
//   pc_out          out 32   IF/ID PC, to ID
// ---------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pc_load,
   input  logic        if_id_load,
   input  logic        mux3_selector,
   input  logic [31:0] branch_address,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction_out,
   output logic [31:0] pc_out
);

   // FETCH : request issued at pc, response may arrive this cycle
   // WAIT  : request outstanding, address held
   // HOLD  : word parked in the hold buffer while ID is stalled, no request
   // DRAIN : request for a pre-redirect address still outstanding; its
   //         response is thrown away
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t      state_q,    state_d;
   logic [31:0] pc_q,       pc_d;
   logic        req_q,      req_d;
   logic [31:0] addr_q,     addr_d;
   logic [31:0] ir_q,       ir_d;
   logic [31:0] ir_pc_q,    ir_pc_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc_q,   buf_pc_d;

   // ------------------------------------------------------------------------
   // Helper terms
   // ------------------------------------------------------------------------
   logic        redirect;
   logic        outstanding;
   logic        word_valid;
   logic [31:0] target;
   logic [31:0] pc_next;

   // A redirect is only meaningful when ID actually consumes the bubble that
   // replaces the wrong-path word; while ID is stalled the branch in ID has
   // not been accepted yet and will be presented again.
   assign redirect = mux3_selector & if_id_load;

   // Masking keeps all bits of branch_address in use while forcing alignment.
   assign target = branch_address & 32'hFFFF_FFFC;

   // Wraps modulo 2^32.
   assign pc_next = pc_q + 32'd4;

   // req_q is low only in HOLD and in the first cycle after reset, so any
   // non-HOLD state with req_q high has a request on the bus.
   assign outstanding = req_q && (state_q != S_HOLD);

   // A returned word is usable only for a live request in FETCH or WAIT.
   assign word_valid = req_q && imem_ready &&
                       ((state_q == S_FETCH) || (state_q == S_WAIT));

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   // NOTE: every variable written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      addr_d      = addr_q;
      ir_d        = ir_q;
      ir_pc_d     = ir_pc_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;

      if (redirect) begin
         // Wrong-path work is dropped: the hold buffer is abandoned and any
         // word returned this cycle is ignored.
         pc_d        = target;
         ir_d        = NOP_INSTR;
         ir_pc_d     = target;
         buf_instr_d = NOP_INSTR;
         buf_pc_d    = target;
         if (outstanding && !imem_ready) begin
            // The memory still owes a response for addr_q; keep presenting
            // that address until it completes.
            state_d = S_DRAIN;
         end else begin
            state_d = S_FETCH;
            addr_d  = target;
         end
      end else begin
         case (state_q)
            S_FETCH, S_WAIT: begin
               if (word_valid) begin
                  if (if_id_load) begin
                     ir_d    = imem_rdata;
                     ir_pc_d = pc_q;
                     if (pc_load) begin
                        pc_d = pc_next;
                     end
                     state_d = S_FETCH;
                     // pc_load=0 leaves pc alone, so the same word is fetched again.
                     addr_d  = pc_load ? pc_next : pc_q;
                  end else begin
                     buf_instr_d = imem_rdata;
                     buf_pc_d    = pc_q;
                     state_d     = S_HOLD;
                  end
               end else begin
                  if (if_id_load) begin
                     ir_d    = NOP_INSTR;
                     ir_pc_d = pc_q;
                  end
                  // The cycle after reset has no request yet; it issues one
                  // and stays in FETCH. Otherwise the request keeps waiting.
                  state_d = req_q ? S_WAIT : S_FETCH;
                  addr_d  = pc_q;
               end
            end

            S_HOLD: begin
               if (if_id_load) begin
                  ir_d        = buf_instr_q;
                  ir_pc_d     = buf_pc_q;
                  buf_instr_d = NOP_INSTR;
                  if (pc_load) begin
                     pc_d = pc_next;
                  end
                  state_d = S_FETCH;
                  addr_d  = pc_load ? pc_next : pc_q;
               end
            end

            S_DRAIN: begin
               if (if_id_load) begin
                  ir_d    = NOP_INSTR;
                  ir_pc_d = pc_q;
               end
               if (imem_ready) begin
                  state_d = S_FETCH;
                  addr_d  = pc_q;
               end
            end

            default: begin
               state_d = S_FETCH;
               addr_d  = pc_q;
            end
         endcase
      end

      // Every state except HOLD has a request on the bus.
      req_d = (state_d != S_HOLD);
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the values computed above before any of them change.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_FETCH;
         pc_q        <= PC_INIT;
         req_q       <= 1'b0;
         addr_q      <= PC_INIT;
         ir_q        <= NOP_INSTR;
         ir_pc_q     <= PC_INIT;
         buf_instr_q <= NOP_INSTR;
         buf_pc_q    <= PC_INIT;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
         ir_q        <= ir_d;
         ir_pc_q     <= ir_pc_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs (all registered)
   // ------------------------------------------------------------------------
   assign imem_req        = req_q;
   assign imem_addr       = addr_q;
   assign instruction_out = ir_q;
   assign pc_out          = ir_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. The memory model answers every
// address a with a | 32'h1000_0000; its ready line is driven per cycle.
// A second instance with RESET_PC = 32'hFFFF_FFFC checks PC wrap-around.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] TAG = 32'h1000_0000;

   logic        clock;
   logic        reset;

   // Main instance
   logic        pc_load, if_id_load, mux3_selector, imem_ready;
   logic [31:0] branch_address;
   logic        imem_req;
   logic [31:0] imem_addr, imem_rdata, instruction_out, pc_out;

   // Wrap-around instance
   logic        pc_load2, if_id_load2, mux3_selector2, imem_ready2;
   logic [31:0] branch_address2;
   logic        imem_req2;
   logic [31:0] imem_addr2, imem_rdata2, instruction_out2, pc_out2;

   int tests_run    = 0;
   int tests_failed = 0;

   assign imem_rdata  = imem_addr  | TAG;
   assign imem_rdata2 = imem_addr2 | TAG;

   instruction_fetch dut (
      .clock          (clock),
      .reset          (reset),
      .pc_load        (pc_load),
      .if_id_load     (if_id_load),
      .mux3_selector  (mux3_selector),
      .branch_address (branch_address),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .instruction_out(instruction_out),
      .pc_out         (pc_out)
   );

   instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clock          (clock),
      .reset          (reset),
      .pc_load        (pc_load2),
      .if_id_load     (if_id_load2),
      .mux3_selector  (mux3_selector2),
      .branch_address (branch_address2),
      .imem_req       (imem_req2),
      .imem_addr      (imem_addr2),
      .imem_ready     (imem_ready2),
      .imem_rdata     (imem_rdata2),
      .instruction_out(instruction_out2),
      .pc_out         (pc_out2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        pl;
      logic        il;
      logic        sel;
      logic [31:0] baddr;
      logic        rdy;
      logic [31:0] e_pc;
      logic [31:0] e_ir;
      logic        e_req;
      logic [31:0] e_addr;
   } vec_t;

   vec_t vecs[21];

   function automatic vec_t mk(logic pl, logic il, logic sel, logic [31:0] baddr,
                               logic rdy, logic [31:0] e_pc, logic [31:0] e_ir,
                               logic e_req, logic [31:0] e_addr);
      vec_t v;
      v.pl = pl; v.il = il; v.sel = sel; v.baddr = baddr; v.rdy = rdy;
      v.e_pc = e_pc; v.e_ir = e_ir; v.e_req = e_req; v.e_addr = e_addr;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_main(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ir,
                             input logic e_req, input logic [31:0] e_addr);
      check({tag, " pc_out"},          pc_out,          e_pc);
      check({tag, " instruction_out"}, instruction_out, e_ir);
      check({tag, " imem_req"},        {31'd0, imem_req}, {31'd0, e_req});
      check({tag, " imem_addr"},       imem_addr,       e_addr);
   endtask

   task automatic check_wrap(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ir,
                             input logic [31:0] e_addr);
      check({tag, " wrap pc_out"},          pc_out2,          e_pc);
      check({tag, " wrap instruction_out"}, instruction_out2, e_ir);
      check({tag, " wrap imem_addr"},       imem_addr2,       e_addr);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // pl il sel baddr rdy | pc_out instr req addr
      // Streaming with ready tied high; first cycle after reset issues the request.
      vecs[0]  = mk(1, 1, 0, 32'h0,   1, 32'h0,   NOP,           1, 32'h0);
      vecs[1]  = mk(1, 1, 0, 32'h0,   1, 32'h0,   TAG | 32'h0,   1, 32'h4);
      vecs[2]  = mk(1, 1, 0, 32'h0,   1, 32'h4,   TAG | 32'h4,   1, 32'h8);
      // Stall two cycles while word 8 returns; it waits in HOLD with no request.
      vecs[3]  = mk(0, 0, 0, 32'h0,   1, 32'h4,   TAG | 32'h4,   0, 32'h8);
      vecs[4]  = mk(0, 0, 0, 32'h0,   1, 32'h4,   TAG | 32'h4,   0, 32'h8);
      // Release: word 8 enters once, fetch moves on to 0xC.
      vecs[5]  = mk(1, 1, 0, 32'h0,   1, 32'h8,   TAG | 32'h8,   1, 32'hC);
      vecs[6]  = mk(1, 1, 0, 32'h0,   1, 32'hC,   TAG | 32'hC,   1, 32'h10);
      // Redirect to 0x43 at pc 0x10: bubble with pc 0x40, next fetch 0x40.
      vecs[7]  = mk(1, 1, 1, 32'h43,  1, 32'h40,  NOP,           1, 32'h40);
      vecs[8]  = mk(1, 1, 0, 32'h0,   1, 32'h40,  TAG | 32'h40,  1, 32'h44);
      // pc_load=0: IF/ID advances, same address fetched again.
      vecs[9]  = mk(0, 1, 0, 32'h0,   1, 32'h44,  TAG | 32'h44,  1, 32'h44);
      vecs[10] = mk(1, 1, 0, 32'h0,   1, 32'h44,  TAG | 32'h44,  1, 32'h48);
      // Slow memory: each wait cycle is a bubble.
      vecs[11] = mk(1, 1, 0, 32'h0,   0, 32'h48,  NOP,           1, 32'h48);
      vecs[12] = mk(1, 1, 0, 32'h0,   0, 32'h48,  NOP,           1, 32'h48);
      // Redirect during WAIT: DRAIN keeps the stale address 0x48.
      vecs[13] = mk(1, 1, 1, 32'h43,  0, 32'h40,  NOP,           1, 32'h48);
      vecs[14] = mk(1, 1, 0, 32'h0,   0, 32'h40,  NOP,           1, 32'h48);
      // Stale response arrives and is dropped; fetch 0x40.
      vecs[15] = mk(1, 1, 0, 32'h0,   1, 32'h40,  NOP,           1, 32'h40);
      vecs[16] = mk(1, 1, 0, 32'h0,   1, 32'h40,  TAG | 32'h40,  1, 32'h44);
      // Stalled WAIT, then a redirect that must be ignored while stalled.
      vecs[17] = mk(0, 0, 0, 32'h0,   0, 32'h40,  TAG | 32'h40,  1, 32'h44);
      vecs[18] = mk(0, 0, 1, 32'h100, 1, 32'h40,  TAG | 32'h40,  0, 32'h44);
      // Redirect beats HOLD release; the buffered word is discarded.
      vecs[19] = mk(1, 1, 1, 32'h201, 0, 32'h200, NOP,           1, 32'h200);
      vecs[20] = mk(1, 1, 0, 32'h0,   1, 32'h200, TAG | 32'h200, 1, 32'h204);

      reset          = 1'b0;
      pc_load        = 1'b1;
      if_id_load     = 1'b1;
      mux3_selector  = 1'b0;
      branch_address = 32'h0;
      imem_ready     = 1'b1;
      pc_load2        = 1'b1;
      if_id_load2     = 1'b1;
      mux3_selector2  = 1'b0;
      branch_address2 = 32'h0;
      imem_ready2     = 1'b1;

      #12;
      check_main("reset", 32'h0, NOP, 1'b0, 32'h0);
      reset = 1'b1;

      for (int i = 0; i < 21; i++) begin
         pc_load        = vecs[i].pl;
         if_id_load     = vecs[i].il;
         mux3_selector  = vecs[i].sel;
         branch_address = vecs[i].baddr;
         imem_ready     = vecs[i].rdy;
         step();
         check_main($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ir,
                    vecs[i].e_req, vecs[i].e_addr);
      end

      // Async reset in the middle of a WAIT, with no clock edge involved.
      pc_load        = 1'b1;
      if_id_load     = 1'b1;
      mux3_selector  = 1'b0;
      branch_address = 32'h0;
      imem_ready     = 1'b0;
      step();
      check_main("pre_reset wait", 32'h204, NOP, 1'b1, 32'h204);
      #2;
      reset = 1'b0;
      #1;
      check_main("async reset", 32'h0, NOP, 1'b0, 32'h0);
      check({"async reset wrap imem_req"}, {31'd0, imem_req2}, 32'd0);
      check_wrap("async reset", 32'hFFFF_FFFC, NOP, 32'hFFFF_FFFC);

      @(negedge clock);
      reset      = 1'b1;
      imem_ready = 1'b1;
      step();
      check_main("post_reset 1", 32'h0, NOP, 1'b1, 32'h0);
      check_wrap("post_reset 1", 32'hFFFF_FFFC, NOP, 32'hFFFF_FFFC);
      step();
      check_main("post_reset 2", 32'h0, TAG | 32'h0, 1'b1, 32'h4);
      check_wrap("post_reset 2", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0);
      step();
      check_wrap("post_reset 3", 32'h0, TAG | 32'h0, 32'h4);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
